seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for the Nexys 3 four-digit common-anode 7-segment display; the output-side counterpart to the debounced button/switch input conditioning.
- Takes hex nibbles, decimal points and per-digit blank flags from the clock/format logic, and scans the digits one at a time.
- Inserts a dead-time (all anodes off) at every digit change to prevent ghosting.
- All outputs are registered.

---
 rtl/seg7_pkg.sv | 9 +
 rtl/hex_to_seg7.sv | 10 +
 rtl/seg7_scan_driver.sv | 94 +++++++++
 tb/tb_seg7_scan_driver.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan driver
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, DRIVE} phase_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low {g,f,e,d,c,b,a} decode
// nib in 4, seg out 7
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with dead-time
// clk, reset (sync, active-high), en, digits_in, dp_in, blank_in, blink_sel in;
// an, seg, dp (all active-low), slot_tick out; all outputs registered.
// SEG7_SCAN_BLINK_EN enables per-digit blinking via blink_sel.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic [DIGITS-1:0]   blink_sel,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                slot_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx;
  logic [3:0] snap_nib, nib;
  logic snap_dp, snap_blank, cur_dp, cur_blank, wrap, entry, blink_off;
  logic [DIGITS-1:0] an_on;
  logic [6:0] dec;
  phase_t ph_nxt;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
  assign ph_nxt = cnt_nxt < CW'(BLANK_CYCLES) ? BLANK : DRIVE;
  assign entry = cnt_nxt == CW'(BLANK_CYCLES);
  // live inputs only at DRIVE entry; the snapshot holds the slot steady afterwards
  assign nib = entry ? digits_in[4*idx +: 4] : snap_nib;
  assign cur_dp = entry ? dp_in[idx] : snap_dp;
  assign cur_blank = entry ? blank_in[idx] | blink_off : snap_blank;
  assign an_on = ~(DIGITS'(1) << idx);
  hex_to_seg7 u_dec (.nib(nib), .seg(dec));
`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] bcnt;
  logic phase_on;
  always_ff @(posedge clk)
    if (reset) begin
      bcnt <= '0;
      phase_on <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt <= '0;
      phase_on <= ~phase_on;
    end else
      bcnt <= bcnt + 1'b1;
  assign blink_off = ~phase_on & blink_sel[idx];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_sel, 32'(BLINK_DIV)};
  assign blink_off = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      snap_nib <= '0;
      snap_dp <= 1'b0;
      snap_blank <= 1'b0;
      an <= '1;
      seg <= SEG_OFF;
      dp <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      slot_tick <= wrap;
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (entry) begin
        snap_nib <= nib;
        snap_dp <= cur_dp;
        snap_blank <= cur_blank;
      end
      if (ph_nxt == BLANK) begin
        an <= '1;
        seg <= SEG_OFF;
        dp <= 1'b1;
      end else begin
        // en only re-enables an anode at DRIVE entry, never mid-slot
        an <= !en ? '1 : entry ? (cur_blank ? '1 : an_on) : an;
        seg <= cur_blank ? SEG_OFF : dec;
        dp <= ~cur_dp;
      end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench against a slot-level reference model
module tb_seg7_scan_driver;
  localparam int D = 4, RD = 8, BC = 2, BD = 64;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0, blink_sel = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, slot_tick;
  logic [6:0] tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int n = 0, total = 0, passed = 0, failed = 0;
  logic [3:0] m_nib = '0, e_an = '1;
  logic m_dp = 1'b0, m_blank = 1'b0, m_lit = 1'b0, e_dp = 1'b1, e_tick = 1'b0;
  logic [6:0] e_seg = 7'h7F;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_sel(blink_sel), .an(an), .seg(seg), .dp(dp),
    .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    logic rs, e, bl;
    logic [15:0] dg;
    logic [3:0] dpv, bk, bs;
    int c, d;
    rs = reset; e = en; dg = digits_in; dpv = dp_in; bk = blank_in; bs = blink_sel;
    @(posedge clk);
    if (rs) begin
      n = 0; e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end else begin
      n++;
      c = n % RD;
      d = (n / RD) % D;
      e_tick = c == 0;
      if (c < BC) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        if (c == BC) begin
          bl = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
          bl = bs[d] && (((n - 1) / BD) % 2 == 1);
`endif
          m_nib = dg[4*d +: 4]; m_dp = dpv[d]; m_blank = bk[d] | bl; m_lit = !m_blank;
        end
        if (!e) m_lit = 1'b0;
        e_an = m_lit ? ~(4'b0001 << d) : 4'hF;
        e_seg = m_blank ? 7'h7F : tab[m_nib];
        e_dp = ~m_dp;
      end
    end
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("slot_tick", slot_tick, e_tick);
    check("one_anode", $countones(~an) <= 1, 1);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0; en = 1'b1; digits_in = 16'h1234;
    repeat (2) step();
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'h19);
    repeat (6) step();
    check("wrap_tick", slot_tick, 1);
    check("wrap_an", an, 4'hF);
    repeat (2) step();
    check("digit1_an", an, 4'b1101);
    check("digit1_seg", seg, 7'h30);
    repeat (30) step();
    dp_in = 4'b0100; blank_in = 4'b1000;
    repeat (40) step();
    blank_in = 4'b0000; dp_in = 4'b0000;
    for (int i = 0; i < 64 && n % 32 != 5; i++) step();
    digits_in[3:0] = 4'hF;
    repeat (32) step();
    for (int i = 0; i < 16 && n % 8 != 4; i++) step();
    en = 1'b0;
    step();
    check("en_off", an, 4'hF);
    step();
    en = 1'b1;
    repeat (20) step();
    for (int i = 0; i < 64 && n % 32 != 19; i++) step();
    reset = 1'b1;
    step();
    check("reset_mid", an, 4'hF);
    reset = 1'b0;
    repeat (2) step();
    check("restart_digit0", an, 4'b1110);
    repeat (20) step();
    blink_sel = 4'b0001;
    repeat (300) step();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) blank_in = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0) blink_sel = 4'($urandom);
      en = $urandom_range(0, 15) != 0;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
